// File: rtl/timer_share_arbiter_if.sv
// Bundle between the per-core timer request registers, the arbiter and the shared
// timer/counter unit. The slave modport is the arbiter's view; master is the environment's.
interface timer_share_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ID_W      = 2
);
  logic [NUM_CORES-1:0]    req;
  logic [16*NUM_CORES-1:0] req_preset;
  logic [NUM_CORES-1:0]    req_mode;
  logic [NUM_CORES-1:0]    gnt;
  logic [NUM_CORES-1:0]    done;
  logic                    busy;
  logic [ID_W-1:0]         active_id;
  logic                    timer_wr_msb;
  logic [7:0]              timer_msb;
  logic                    timer_wr_lsb;
  logic [7:0]              timer_lsb;
  logic                    timercounter_en;
  logic                    timercounter_mode;
  logic                    timer_ov;

  modport master (
    output req, req_preset, req_mode, timer_ov,
    input  gnt, done, busy, active_id, timer_wr_msb, timer_msb, timer_wr_lsb, timer_lsb,
           timercounter_en, timercounter_mode
  );

  modport slave (
    input  req, req_preset, req_mode, timer_ov,
    output gnt, done, busy, active_id, timer_wr_msb, timer_msb, timer_wr_lsb, timer_lsb,
           timercounter_en, timercounter_mode
  );
endinterface

// File: rtl/timer_share_arbiter.sv
// Round-robin sharing of one timer/counter unit between NUM_CORES cores: load the granted
// core's 16-bit preset (MSB then LSB), count until overflow, then pulse DONE to that core.
module timer_share_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ID_W      = 2
) (
  input logic                   CLK,
  input logic                   CPU_Reset_n,
  timer_share_arbiter_if.slave  arb_io
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {StIdle, StLoadMsb, StLoadLsb, StRun, StFinish} state_e;

  state_e               state_q;
  logic [NUM_CORES-1:0] gnt_q;
  logic [ID_W-1:0]      active_id_q;
  logic [7:0]           msb_q;
  logic [7:0]           lsb_q;
  logic                 mode_q;
  logic                 ran_q;
  logic [IdxW-1:0]      rr_q;

  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic [15:0]     win_preset;
  logic            req_held;
  logic            stop;

  // First requester after the last winner, wrapping modulo NUM_CORES.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = IdxW'((32'(rr_q) + k) % NUM_CORES);
      if (!win_vld && arb_io.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_preset = arb_io.req_preset[16*win_idx +: 16];
  assign req_held   = |(arb_io.req & gnt_q);

  // In up mode the unit starts away from zero, but a stale OV can still be high in the first
  // RUN cycle; in down mode OV must stop the count at once or the unit wraps to FFFF.
  assign stop = arb_io.timer_ov && (ran_q || !mode_q);

  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      active_id_q <= '0;
      msb_q       <= '0;
      lsb_q       <= '0;
      mode_q      <= 1'b0;
      ran_q       <= 1'b0;
      rr_q        <= IdxW'(NUM_CORES - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q     <= StLoadMsb;
            gnt_q       <= NUM_CORES'(1) << win_idx;
            active_id_q <= ID_W'(win_idx);
            msb_q       <= win_preset[15:8];
            lsb_q       <= win_preset[7:0];
            mode_q      <= arb_io.req_mode[win_idx];
            rr_q        <= win_idx;
          end
        end
        StLoadMsb: begin
          state_q <= req_held ? StLoadLsb : StIdle;
        end
        StLoadLsb: begin
          ran_q   <= 1'b0;
          state_q <= req_held ? StRun : StIdle;
        end
        StRun: begin
          ran_q <= 1'b1;
          if (!req_held) begin
            state_q <= StIdle;
          end else if (stop) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      // Abort or completion both leave the grant.
      if ((state_q == StFinish) ||
          ((state_q inside {StLoadMsb, StLoadLsb, StRun}) && !req_held)) begin
        gnt_q       <= '0;
        active_id_q <= '0;
      end
    end
  end

  assign arb_io.gnt               = gnt_q;
  assign arb_io.done              = (state_q == StFinish) ? gnt_q : '0;
  assign arb_io.busy              = (state_q != StIdle);
  assign arb_io.active_id         = active_id_q;
  assign arb_io.timer_wr_msb      = (state_q == StLoadMsb);
  assign arb_io.timer_msb         = msb_q;
  assign arb_io.timer_wr_lsb      = (state_q == StLoadLsb);
  assign arb_io.timer_lsb         = lsb_q;
  assign arb_io.timercounter_en   = (state_q == StRun) && !stop;
  assign arb_io.timercounter_mode = mode_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Bench for timer_share_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model and a simple model of the shared timer/counter unit.
module tb_timer_share_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;

  logic CLK = 1'b0;
  logic CPU_Reset_n = 1'b0;
  always #5 CLK = ~CLK;

  timer_share_arbiter_if #(.NUM_CORES(NC), .ID_W(IW)) bus ();

  timer_share_arbiter #(.NUM_CORES(NC), .ID_W(IW)) dut (
    .CLK         (CLK),
    .CPU_Reset_n (CPU_Reset_n),
    .arb_io      (bus.slave)
  );

  // Shared timer/counter unit: byte loads, up/down count, OV = counter is zero.
  logic [15:0] tcnt  = 16'h1234;
  logic [15:0] t_nxt = 16'h1234;
  always @(posedge CLK) tcnt <= t_nxt;
  assign bus.timer_ov = (tcnt == 16'h0000);

  int n_vec = 0;
  int n_err = 0;

  // Model: an operation is a numbered sequence of cycles after the grant edge.
  // k=1 MSB load, k=2 LSB load, k=3..2+n counting, k=3+n stop, k=4+n done.
  bit          m_busy;
  int          m_win, m_k, m_n, m_rr;
  logic [15:0] m_pre;
  logic        m_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_rr   = NC - 1;
    m_win  = 0;
    m_k    = 0;
    m_n    = 0;
  endfunction

  function automatic void model_step();
    int c;
    if (!CPU_Reset_n) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (m_k <= 3 + m_n && !bus.req[m_win]) m_busy = 1'b0;
      else if (m_k == 4 + m_n) m_busy = 1'b0;
      else m_k++;
    end else if (|bus.req) begin
      for (int s = 1; s <= NC; s++) begin
        c = (m_rr + s) % NC;
        if (bus.req[c]) begin
          m_win = c;
          break;
        end
      end
      m_rr   = m_win;
      m_pre  = bus.req_preset[16*m_win +: 16];
      m_mode = bus.req_mode[m_win];
      m_n    = m_mode ? 65536 - int'(m_pre) : int'(m_pre);
      m_k    = 1;
      m_busy = 1'b1;
    end
  endfunction

  task automatic check_all();
    logic [NC-1:0] eg, ed;
    eg = '0;
    ed = '0;
    if (m_busy) eg[m_win] = 1'b1;
    if (m_busy && m_k == 4 + m_n) ed[m_win] = 1'b1;
    chk("gnt", bus.gnt, eg);
    chk("done", bus.done, ed);
    chk("busy", bus.busy, m_busy);
    chk("active_id", bus.active_id, m_busy ? m_win : 0);
    chk("wr_msb", bus.timer_wr_msb, m_busy && m_k == 1);
    chk("wr_lsb", bus.timer_wr_lsb, m_busy && m_k == 2);
    chk("en", bus.timercounter_en, m_busy && m_k >= 3 && m_k < 3 + m_n);
    if (m_busy) begin
      chk("msb", bus.timer_msb, m_pre[15:8]);
      chk("lsb", bus.timer_lsb, m_pre[7:0]);
      chk("mode", bus.timercounter_mode, m_mode);
    end
  endtask

  // Inputs are set before the call; they are sampled at the coming rising edge.
  task automatic tick();
    logic [15:0] tn;
    tn = tcnt;
    if (bus.timer_wr_msb) tn[15:8] = bus.timer_msb;
    if (bus.timer_wr_lsb) tn[7:0] = bus.timer_lsb;
    if (bus.timercounter_en) tn = bus.timercounter_mode ? tn + 16'd1 : tn - 16'd1;
    t_nxt = tn;
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  function automatic int onehot_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic run_one(input string nm, input int core, input logic [15:0] p, input logic m,
                         input int exp_en, input int exp_done);
    int            c_msb, c_lsb, n_en, c_done;
    logic [7:0]    msb_seen, lsb_seen;
    logic [NC-1:0] done_seen, ed;
    bit            mode_bad;
    c_msb = -1; c_lsb = -1; n_en = 0; c_done = -1;
    msb_seen = '0; lsb_seen = '0; done_seen = '0; mode_bad = 1'b0;
    ed = '0;
    ed[core] = 1'b1;
    bus.req_preset[16*core +: 16] = p;
    bus.req_mode[core] = m;
    bus.req = '0;
    bus.req[core] = 1'b1;
    for (int c = 1; c <= exp_done + 3; c++) begin
      tick();
      if (bus.timer_wr_msb) begin c_msb = c; msb_seen = bus.timer_msb; end
      if (bus.timer_wr_lsb) begin c_lsb = c; lsb_seen = bus.timer_lsb; end
      if (bus.timercounter_en) n_en++;
      if (bus.busy && bus.timercounter_mode !== m) mode_bad = 1'b1;
      if (|bus.done) begin c_done = c; done_seen = bus.done; bus.req[core] = 1'b0; end
    end
    chk({nm, "_wr_msb_cycle"}, c_msb, 1);
    chk({nm, "_wr_lsb_cycle"}, c_lsb, 2);
    chk({nm, "_msb_value"}, msb_seen, p[15:8]);
    chk({nm, "_lsb_value"}, lsb_seen, p[7:0]);
    chk({nm, "_en_cycles"}, n_en, exp_en);
    chk({nm, "_done_cycle"}, c_done, exp_done);
    chk({nm, "_done_vec"}, done_seen, ed);
    chk({nm, "_timer_final"}, tcnt, 16'h0000);
    chk({nm, "_mode_stable"}, mode_bad, 1'b0);
  endtask

  task automatic rand_presets();
    logic m;
    for (int i = 0; i < NC; i++) begin
      m = 1'($urandom_range(0, 1));
      bus.req_mode[i] = m;
      bus.req_preset[16*i +: 16] = m ? (16'hFFE0 | 16'($urandom_range(0, 31)))
                                     : 16'($urandom_range(0, 31));
    end
  endtask

  initial begin
    int            n_en, c5_en, c5_busy, ng, last_done;
    int            order[5];
    int            exp_ord[5];
    logic [NC-1:0] g6, prev_g;
    bit            core2_done;

    bus.req = '0;
    bus.req_preset = '0;
    bus.req_mode = '0;
    model_reset();

    // Reset state.
    #12;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_active_id", bus.active_id, 0);
    chk("rst_strobes", {bus.timer_wr_msb, bus.timer_wr_lsb, bus.timercounter_en}, 0);
    chk("rst_data", {bus.timer_msb, bus.timer_lsb, bus.timercounter_mode}, 0);
    @(negedge CLK);
    CPU_Reset_n = 1'b1;

    run_one("down5", 0, 16'h0005, 1'b0, 5, 9);
    run_one("upfffe", 1, 16'hFFFE, 1'b1, 2, 6);
    run_one("down0", 2, 16'h0000, 1'b0, 0, 4);

    // Core 2 drops REQ after two counting cycles while core 3 is pending.
    bus.req = '0;
    bus.req_preset[32 +: 16] = 16'd10; bus.req_mode[2] = 1'b0;
    bus.req_preset[48 +: 16] = 16'd2;  bus.req_mode[3] = 1'b0;
    bus.req[2] = 1'b1;
    n_en = 0; c5_en = -1; c5_busy = -1; g6 = '0; core2_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) bus.req[3] = 1'b1;
      if (c <= 4 && bus.timercounter_en) n_en++;
      if (bus.done[2]) core2_done = 1'b1;
      if (c == 4) bus.req[2] = 1'b0;
      if (c == 5) begin c5_en = int'(bus.timercounter_en); c5_busy = int'(bus.busy); end
      if (c == 6) g6 = bus.gnt;
      if (bus.done[3]) bus.req[3] = 1'b0;
    end
    chk("abort_en_before", n_en, 2);
    chk("abort_en_after", c5_en, 0);
    chk("abort_busy_after", c5_busy, 0);
    chk("abort_no_done", core2_done, 1'b0);
    chk("abort_next_gnt", g6, 4'b1000);

    // Asynchronous reset in the middle of a count.
    bus.req = '0;
    bus.req_preset[16 +: 16] = 16'd20; bus.req_mode[1] = 1'b0;
    bus.req[1] = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    chk("rst_pre_en", bus.timercounter_en, 1'b1);
    #2 CPU_Reset_n = 1'b0;
    #1;
    chk("rst_async_gnt", bus.gnt, 0);
    chk("rst_async_en", bus.timercounter_en, 0);
    chk("rst_async_busy", bus.busy, 0);
    model_reset();
    bus.req = '0;
    tick();
    tick();
    CPU_Reset_n = 1'b1;

    // All cores requesting continuously, each with a preset of 3 counting down.
    for (int i = 0; i < NC; i++) begin
      bus.req_preset[16*i +: 16] = 16'd3;
      bus.req_mode[i] = 1'b0;
    end
    exp_ord = '{0, 1, 2, 3, 0};
    order = '{-1, -1, -1, -1, -1};
    ng = 0; last_done = -1; prev_g = '0;
    bus.req = '1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.gnt != 0 && prev_g == 0) begin
        if (ng < 5) order[ng] = onehot_idx(bus.gnt);
        if (last_done >= 0) chk("rr_done_to_gnt", c - last_done, 2);
        ng++;
      end
      if (|bus.done) last_done = c;
      prev_g = bus.gnt;
    end
    bus.req = '0;
    chk("rr_grant_count", ng, 5);
    for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_ord[i]);
    for (int c = 0; c < 4; c++) tick();

    // Random traffic: requests held until DONE, occasional aborts, presets churning.
    for (int t = 0; t < 3000; t++) begin
      rand_presets();
      for (int i = 0; i < NC; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b1;
        end else if (bus.done[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_share_arbiter.md
Name: timer_share_arbiter

Overview:
- Shares one TIMERCOUNTER_UNIT between NUM_CORES PLC cores.
- Arbitrates core timer requests round-robin.
- For the granted core, it loads the 16-bit preset into the unit (MSB write, then LSB write), enables counting in the requested mode, and watches TIMER_OV.
- On overflow it stops the unit and returns a one-cycle DONE to that core.
- Sits between the per-core timer request registers and the single timer/counter instance.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ID_W, 2, width of ACTIVE_ID; must be at least clog2(NUM_CORES).

Ports:
- CLK  in  1  system clock.
- CPU_Reset_n  in  1  asynchronous, active-low reset.
- REQ  in  NUM_CORES  per-core request level; held until DONE.
- REQ_PRESET  in  16*NUM_CORES  per-core preset; core i uses bits [16i+15:16i].
- REQ_MODE  in  NUM_CORES  per-core mode; 1 = count up, 0 = count down.
- GNT  out  NUM_CORES  one-hot grant, held from LOAD_MSB through DONE.
- DONE  out  NUM_CORES  one-hot completion pulse, one cycle.
- BUSY  out  1  high when the state is not IDLE.
- ACTIVE_ID  out  ID_W  index of the granted core; 0 when idle.
- TIMER_WR_MSB  out  1  MSB load strobe to the unit.
- TIMER_MSB  out  8  latched preset[15:8].
- TIMER_WR_LSB  out  1  LSB load strobe to the unit.
- TIMER_LSB  out  8  latched preset[7:0].
- TIMERCOUNTER_EN  out  1  count enable to the unit.
- TIMERCOUNTER_MODE  out  1  latched mode of the granted core.
- TIMER_OV  in  1  counter==0 flag from the unit.

Behaviour:
- Reset (async, CPU_Reset_n low):
  - state = IDLE; all outputs 0.
  - rr_last = NUM_CORES-1, so core 0 wins first.
  - Asserting reset mid-operation drops EN and GNT immediately, with no DONE.
- States: IDLE, LOAD_MSB, LOAD_LSB, RUN, FINISH.
- IDLE:
  - If any REQ bit is high at a clock edge, the winner is the first set bit searching rr_last+1, rr_last+2, … modulo NUM_CORES.
  - On that edge: latch its preset and mode, set GNT/ACTIVE_ID, update rr_last to the winner, go to LOAD_MSB.
- LOAD_MSB: TIMER_WR_MSB=1 for one cycle; go to LOAD_LSB.
- LOAD_LSB: TIMER_WR_LSB=1 for one cycle; go to RUN.
- TIMER_MSB, TIMER_LSB and TIMERCOUNTER_MODE are stable from grant until return to IDLE.
- RUN:
  - A `ran` flag clears on entry and sets after the first RUN cycle.
  - TIMERCOUNTER_EN is combinational: RUN && !stop, where stop = TIMER_OV && (ran || !mode).
  - EN therefore drops in the same cycle OV is seen. The unit does not guard its own zero in down mode, so this gating is mandatory to prevent wrap to FFFF.
  - Go to FINISH at the edge where stop is high.
- FINISH: DONE[winner]=1 for exactly one cycle, GNT still held; go to IDLE and clear GNT/ACTIVE_ID.
- Count durations:
  - Down mode, preset P: P EN cycles. P=0 gives 0 EN cycles.
  - Up mode, preset P: 65536-P EN cycles. P=0 gives 65536.
- Latency, with REQ sampled at edge 0:
  - LOAD_MSB in cycle 1, LOAD_LSB in cycle 2.
  - RUN in cycles 3 .. 3+N, where N = EN cycles.
  - DONE in cycle 4+N.
- Abort: if REQ[winner] is low at any edge in LOAD_MSB, LOAD_LSB or RUN, go to IDLE next cycle, EN=0, no DONE. The timer keeps its value.
- Other cores' REQ changes never affect an operation in progress.
- Re-request: a core still asserting REQ after its DONE is treated as a new request. Round-robin ensures other pending cores are served first.
- No WR strobe is ever asserted together with EN. WR_MSB and WR_LSB are never asserted in the same cycle.

Test Plan:
- Reset release, REQ=0001, preset[0]=0x0005, mode 0 -> WR_MSB cycle 1 (MSB=0x00), WR_LSB cycle 2 (LSB=0x05), EN high exactly 5 cycles, DONE=0001 in cycle 9; timer ends at 0x0000, not 0xFFFF.
- REQ=0010, preset 0xFFFE, mode 1 -> EN high 2 cycles, DONE=0010 in cycle 6; TIMERCOUNTER_MODE=1 throughout.
- Down mode, preset 0x0000 -> EN never high, DONE in cycle 4.
- REQ=1111 held continuously, each core with preset 3 -> grants in order 0,1,2,3,0; each DONE precedes the next GNT by exactly one cycle (IDLE gap).
- Core 2 drops REQ during RUN after 2 EN cycles (preset 10) -> EN low next cycle, no DONE, BUSY low the following cycle, next pending core granted.
- Reset asserted during RUN -> GNT, EN and BUSY go 0 asynchronously; after release core 0 has priority again.
